poly_rq_to_s3: RTL and testbench

POLY_RQ_TO_S3 -- requirements
Module: poly_rq_to_s3

---
 rtl/ntru_pkg.sv | 35 +++
 rtl/mod3_13b.sv | 28 ++
 rtl/poly_rq_to_s3.sv | 100 ++++++++++
 tb/tb_poly_rq_to_s3.sv | 192 +++++++++++++++++++
 4 files changed

// File: rtl/ntru_pkg.sv
// rtl/ntru_pkg.sv - shared NTRU sizes, ternary codes, FSM states and ternary arithmetic
package ntru_pkg;

    localparam int N    = 701;
    localparam int LOGQ = 13;

    localparam logic [1:0] T_ZERO = 2'b00;
    localparam logic [1:0] T_POS  = 2'b01;
    localparam logic [1:0] T_NEG  = 2'b11;

    typedef enum logic {
        LOAD  = 1'b0,
        DRAIN = 1'b1
    } state_t;

    function automatic int t_val(input logic [1:0] t);
        case (t)
            T_POS:   t_val = 1;
            T_NEG:   t_val = -1;
            default: t_val = 0;
        endcase
    endfunction

    // a - b, folded back into the centred range {-1, 0, +1}
    function automatic logic [1:0] t_sub(input logic [1:0] a, input logic [1:0] b);
        int d;
        d = t_val(a) - t_val(b);
        case (d)
            1, -2:   t_sub = T_POS;
            -1, 2:   t_sub = T_NEG;
            default: t_sub = T_ZERO;
        endcase
    endfunction

endpackage

// File: rtl/mod3_13b.sv
// rtl/mod3_13b.sv - signed 13-bit value reduced mod 3 to a centred ternary code
module mod3_13b
    import ntru_pkg::*;
(
    input  logic [12:0] v,
    output logic [1:0]  t
);

    logic [4:0] r;

    // 2^k mod 3 alternates 1,2; the sign bit (-4096) is also 2 mod 3
    always_comb begin
        r = 5'd0;
        for (int i = 0; i < 12; i++) begin
            if (i[0])
                r = r + {3'b000, v[i], 1'b0};
            else
                r = r + {4'b0000, v[i]};
        end
        r = r + {3'b000, v[12], 1'b0};
        case (r % 5'd3)
            5'd0:    t = T_ZERO;
            5'd1:    t = T_POS;
            default: t = T_NEG;
        endcase
    end

endmodule

// File: rtl/poly_rq_to_s3.sv
// rtl/poly_rq_to_s3.sv - streams an R_q polynomial in and its S3 image out
module poly_rq_to_s3
    import ntru_pkg::state_t, ntru_pkg::LOAD, ntru_pkg::DRAIN, ntru_pkg::T_ZERO, ntru_pkg::t_sub;
#(
    parameter int N    = ntru_pkg::N,
    parameter int LOGQ = ntru_pkg::LOGQ
) (
    input  logic            clk,
    input  logic            rst,
    input  logic [LOGQ-1:0] in_data,
    input  logic            in_valid,
    output logic            in_ready,
    output logic [1:0]      out_data,
    output logic            out_valid,
    input  logic            out_ready,
    output logic            out_last
);

    localparam int            CW   = (N > 1) ? $clog2(N) : 1;
    localparam logic [CW-1:0] LAST = CW'(N - 1);

    state_t        state;
    logic [CW-1:0] in_cnt;
    logic [CW-1:0] out_cnt;
    logic [CW-1:0] nxt;
    logic [1:0]    t_in;
    logic [1:0]    t_last;
    logic [1:0]    first_t;
    logic [12:0]   v13;
    logic [1:0]    tbuf [N];
    logic          in_fire;
    logic          out_fire;

    assign v13      = 13'($signed(in_data));
    assign in_fire  = in_valid && in_ready;
    assign out_fire = out_valid && out_ready;
    assign nxt      = out_cnt + 1'b1;
    assign first_t  = (N == 1) ? t_in : tbuf[0];

    mod3_13b u_mod3 (
        .v (v13),
        .t (t_in)
    );

    always_ff @(posedge clk) begin
        if (in_fire)
            tbuf[in_cnt] <= t_in;
    end

    // out_data is precomputed one beat ahead so every output stays registered
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= LOAD;
            in_cnt    <= '0;
            out_cnt   <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_data  <= T_ZERO;
            t_last    <= T_ZERO;
        end else begin
            case (state)
                LOAD: begin
                    if (in_fire) begin
                        if (in_cnt == LAST) begin
                            state     <= DRAIN;
                            in_cnt    <= '0;
                            in_ready  <= 1'b0;
                            out_valid <= 1'b1;
                            out_cnt   <= '0;
                            t_last    <= t_in;
                            out_data  <= t_sub(first_t, t_in);
                            out_last  <= (N == 1);
                        end else begin
                            in_cnt <= in_cnt + 1'b1;
                        end
                    end
                end
                DRAIN: begin
                    if (out_fire) begin
                        if (out_cnt == LAST) begin
                            state     <= LOAD;
                            out_cnt   <= '0;
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_data  <= T_ZERO;
                            in_ready  <= 1'b1;
                        end else begin
                            out_cnt  <= nxt;
                            out_data <= t_sub(tbuf[nxt], t_last);
                            out_last <= (nxt == LAST);
                        end
                    end
                end
                default: state <= LOAD;
            endcase
        end
    end

endmodule

// File: tb/tb_poly_rq_to_s3.sv
// tb/tb_poly_rq_to_s3.sv - table-driven self-checking bench for poly_rq_to_s3
module tb_poly_rq_to_s3;

    localparam int N    = 701;
    localparam int LOGQ = 13;

    logic            clk = 1'b0;
    logic            rst;
    logic [LOGQ-1:0] in_data;
    logic            in_valid;
    logic            in_ready;
    logic [1:0]      out_data;
    logic            out_valid;
    logic            out_ready;
    logic            out_last;

    int n_vec = 0;
    int n_err = 0;

    logic [12:0] cf [N];
    logic [1:0]  ex [N];

    typedef struct {
        logic [12:0] c0, c1, c2, cm, cl;
        logic [1:0]  e0, e1, e2, em, el;
        bit          gaps, stalls;
    } vec_t;

    vec_t tbl [6];

    poly_rq_to_s3 #(.N(N), .LOGQ(LOGQ)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_last  (out_last)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        n_vec++;
        if (act !== req) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    function automatic logic [1:0] model_t(input logic [12:0] c);
        int v, r;
        v = int'($signed(c));
        r = ((v % 3) + 3) % 3;
        return (r == 0) ? 2'b00 : (r == 1) ? 2'b01 : 2'b11;
    endfunction

    function automatic int tv(input logic [1:0] t);
        return (t == 2'b01) ? 1 : (t == 2'b11) ? 2 : 0;
    endfunction

    function automatic logic [1:0] model_s(input logic [1:0] a, input logic [1:0] b);
        int d;
        d = (tv(a) - tv(b) + 3) % 3;
        return (d == 0) ? 2'b00 : (d == 1) ? 2'b01 : 2'b11;
    endfunction

    task automatic feed(input int cnt, input bit gaps);
        int idx = 0;
        int budget = 0;
        bit ov_seen = 0;
        while (idx < cnt) begin
            @(negedge clk);
            if (out_valid) ov_seen = 1;
            in_data  = cf[idx];
            in_valid = gaps ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (in_valid && in_ready) idx++;
            if (++budget > 20 * N) begin
                check("feed_timeout", 32'(idx), 32'(cnt));
                break;
            end
        end
        check("load_out_valid_low", 32'(ov_seen), 32'd0);
    endtask

    task automatic drain(input bit stalls);
        int  j = 0;
        int  budget = 0;
        bit  held = 0;
        bit  ir_seen = 0;
        logic [1:0] pd;
        logic       pl;
        @(negedge clk);
        in_valid = 1'b0;
        check("out_valid_rise", 32'(out_valid), 32'd1);
        while (j < N) begin
            if (in_ready) ir_seen = 1;
            if (held) begin
                check("stall_data_hold", 32'(out_data), 32'(pd));
                check("stall_last_hold", 32'(out_last), 32'(pl));
            end
            out_ready = stalls ? ($urandom_range(0, 1) == 1) : 1'b1;
            if (out_valid && out_ready) begin
                check($sformatf("out_data[%0d]", j), 32'(out_data), 32'(ex[j]));
                check($sformatf("out_last[%0d]", j), 32'(out_last), 32'(j == N - 1));
                j++;
            end
            held = out_valid && !out_ready;
            pd   = out_data;
            pl   = out_last;
            if (j < N) begin
                @(negedge clk);
                if (++budget > 20 * N) begin
                    check("drain_timeout", 32'(j), 32'(N));
                    break;
                end
            end
        end
        @(negedge clk);
        out_ready = 1'b0;
        check("drain_in_ready_low", 32'(ir_seen), 32'd0);
        check("in_ready_rise", 32'(in_ready), 32'd1);
        check("out_valid_fall", 32'(out_valid), 32'd0);
    endtask

    task automatic load_vec(input vec_t v);
        for (int i = 0; i < N; i++) begin
            cf[i] = v.cm;
            ex[i] = v.em;
        end
        cf[0] = v.c0;  ex[0] = v.e0;
        cf[1] = v.c1;  ex[1] = v.e1;
        cf[2] = v.c2;  ex[2] = v.e2;
        cf[N-1] = v.cl; ex[N-1] = v.el;
    endtask

    initial begin
        tbl[0] = '{13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h0000, 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 1'b0};
        tbl[1] = '{13'h0001, 13'h0001, 13'h0001, 13'h0001, 13'h0000, 2'b01, 2'b01, 2'b01, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[2] = '{13'h0000, 13'h0000, 13'h0000, 13'h0000, 13'h0001, 2'b11, 2'b11, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0};
        tbl[3] = '{13'h1FFF, 13'h1000, 13'h0FFF, 13'h0000, 13'h1FFE, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 1'b0, 1'b0};
        tbl[4] = '{13'h0002, 13'h1FFD, 13'h0004, 13'h0003, 13'h1FFF, 2'b00, 2'b01, 2'b11, 2'b01, 2'b00, 1'b0, 1'b0};
        tbl[5] = '{13'h1FFF, 13'h1000, 13'h0FFF, 13'h0000, 13'h1FFE, 2'b01, 2'b01, 2'b11, 2'b11, 2'b00, 1'b1, 1'b1};

        rst       = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        rst = 1'b1;

        for (int k = 0; k < 6; k++) begin
            load_vec(tbl[k]);
            feed(N, tbl[k].gaps);
            drain(tbl[k].stalls);
        end

        for (int i = 0; i < N; i++) cf[i] = 13'($urandom);
        for (int i = 0; i < N; i++) ex[i] = model_s(model_t(cf[i]), model_t(cf[N-1]));
        feed(N, 1'b1);
        drain(1'b1);

        load_vec(tbl[1]);
        feed(300, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b0;
        #1;
        check("midrst_in_ready", 32'(in_ready), 32'd1);
        check("midrst_out_valid", 32'(out_valid), 32'd0);
        check("midrst_out_data", 32'(out_data), 32'd0);
        @(negedge clk);
        rst = 1'b1;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check("post_rst_out_valid", 32'(out_valid), 32'd0);
            check("post_rst_in_ready", 32'(in_ready), 32'd1);
        end
        feed(N, 1'b0);
        drain(1'b0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
